// File: rtl/button_pkg.sv
// button_pkg
//   Shared types and default constants for the push-button debouncer.
//   - db_state_t        : debounce filter FSM state encoding
//   - DEF_SYNC_STAGES   : default synchronizer depth (minimum 2)
//   - DEF_DEBOUNCE_CYCLES : default number of consecutive stable samples
//                         required before the output follows (minimum 2)
package button_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 32;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } db_state_t;

    // True for states in which the debounced output is high.
    function automatic logic state_level(input db_state_t st);
        return (st == STABLE_HI) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain
//   N-flop synchronizer bringing an asynchronous level into the clk domain.
//   All flops clear to 0 on a synchronous active-high reset.
//   Ports:
//     clk  - sampling clock
//     rst  - synchronous active-high reset
//     d    - asynchronous input level
//     q    - synchronised level (last flop of the chain)
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/button_debounce.sv
// button_debounce
//   Debouncer for one mechanical push-button. The raw pin is synchronised,
//   then a four-state filter only lets the output follow once the
//   synchronised level has differed from the output for DEBOUNCE_CYCLES
//   consecutive clocks. Any sample agreeing with the output during a wait
//   throws the partial count away.
//   Ports:
//     clk  - system clock, all state changes on the rising edge
//     rst  - synchronous active-high reset (dominates everything)
//     in   - raw, asynchronous, bouncy button level
//     out  - debounced level, straight from a flop
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   STABLE_LO | out=0, synchronised input agrees, counter idle at 0
//   WAIT_HI   | out=0, input seen high, counting consecutive high samples
//   STABLE_HI | out=1, synchronised input agrees, counter idle at 0
//   WAIT_LO   | out=1, input seen low, counting consecutive low samples
module button_debounce
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic          s;
    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          out_nxt;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (s)
    );

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE_LO;
            count <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            out   <= out_nxt;
        end
    end

    // Next state and counter. The first differing sample already counts as
    // one, so the DEBOUNCE_CYCLES-th consecutive sample is the one that
    // commits the transition. The counter is cleared on every state change
    // and therefore never reaches a wrapping value.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    state_nxt = WAIT_HI;
                    count_nxt = ONE;
                end else begin
                    count_nxt = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt = STABLE_LO;
                    count_nxt = '0;
                end else if (count == LAST) begin
                    state_nxt = STABLE_HI;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_nxt = WAIT_LO;
                    count_nxt = ONE;
                end else begin
                    count_nxt = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt = STABLE_HI;
                    count_nxt = '0;
                end else if (count == LAST) begin
                    state_nxt = STABLE_LO;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                count_nxt = '0;
            end
        endcase
    end

    // Output level is a pure function of the state being entered, so the
    // registered out changes on the same edge as the committing transition.
    always_comb begin
        out_nxt = state_level(state_nxt);
    end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int NS = 2;
    localparam int ND = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic out;

    int n_vec = 0;
    int n_bad = 0;

    button_debounce #(
        .SYNC_STAGES     (NS),
        .DEBOUNCE_CYCLES (ND)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    always #10 clk = ~clk;

    // Reference model: out flips once the last ND samples seen by the
    // filter (the pin value from NS edges earlier) all disagree with it.
    bit hist[$];
    bit m_out;

    task automatic model_edge(input bit r, input bit v);
        bit all_diff;
        if (r) begin
            hist.delete();
            for (int i = 0; i < NS + ND; i++) hist.push_back(1'b0);
            m_out = 1'b0;
        end else begin
            all_diff = 1'b1;
            hist.push_back(v);
            for (int j = 0; j < ND; j++)
                if (hist[hist.size() - 1 - NS - j] == m_out) all_diff = 1'b0;
            if (all_diff) m_out = ~m_out;
            if (hist.size() > NS + ND + 4) void'(hist.pop_front());
        end
    endtask

    task automatic step(input bit r, input bit v);
        rst = r;
        in  = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
    endtask

    task automatic check(input string name, input bit exp);
        n_vec++;
        if (out !== exp) begin
            n_bad++;
            $display("FAIL %s: out=%0b expected %0b at %0t", name, out, exp, $time);
        end
    endtask

    typedef struct {
        bit    r;
        bit    v;
        int    cycles;
        bit    exp;
        bit    every;
        string name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit lvl;
        int len;

        // rst, in, cycles, expected out, check every cycle, name
        vecs.push_back('{1'b1, 1'b0, 1,   1'b0, 1'b1, "reset"});
        vecs.push_back('{1'b0, 1'b0, 100, 1'b0, 1'b1, "idle_lo"});
        vecs.push_back('{1'b0, 1'b1, 10,  1'b0, 1'b1, "short_hi"});
        vecs.push_back('{1'b0, 1'b0, 40,  1'b0, 1'b1, "after_short_hi"});
        vecs.push_back('{1'b0, 1'b1, 33,  1'b0, 1'b1, "rise_wait"});
        vecs.push_back('{1'b0, 1'b1, 1,   1'b1, 1'b1, "rise_edge33"});
        vecs.push_back('{1'b0, 1'b1, 30,  1'b1, 1'b1, "hold_hi_64"});
        vecs.push_back('{1'b0, 1'b0, 10,  1'b1, 1'b1, "short_lo"});
        vecs.push_back('{1'b0, 1'b1, 40,  1'b1, 1'b1, "after_short_lo"});
        vecs.push_back('{1'b0, 1'b0, 33,  1'b1, 1'b1, "fall_wait"});
        vecs.push_back('{1'b0, 1'b0, 1,   1'b0, 1'b1, "fall_edge33"});
        vecs.push_back('{1'b0, 1'b0, 30,  1'b0, 1'b1, "hold_lo_64"});
        vecs.push_back('{1'b0, 1'b1, 32,  1'b0, 1'b1, "pulse32"});
        vecs.push_back('{1'b0, 1'b0, 1,   1'b0, 1'b1, "pulse32_tail"});
        vecs.push_back('{1'b0, 1'b0, 1,   1'b1, 1'b1, "pulse32_accept"});
        vecs.push_back('{1'b0, 1'b0, 40,  1'b0, 1'b0, "pulse32_return"});
        vecs.push_back('{1'b0, 1'b1, 31,  1'b0, 1'b1, "pulse31"});
        vecs.push_back('{1'b0, 1'b0, 40,  1'b0, 1'b1, "pulse31_reject"});
        for (int p = 0; p < 25; p++) begin
            vecs.push_back('{1'b0, 1'b1, 5, 1'b0, 1'b1, "bounce_hi"});
            vecs.push_back('{1'b0, 1'b0, 3, 1'b0, 1'b1, "bounce_lo"});
        end

        for (int k = 0; k < vecs.size(); k++) begin
            for (int c = 0; c < vecs[k].cycles; c++) begin
                step(vecs[k].r, vecs[k].v);
                if (vecs[k].every || c == vecs[k].cycles - 1)
                    check(vecs[k].name, vecs[k].exp);
            end
        end

        // Reset in the middle of a high wait (count 20) must discard it.
        for (int c = 0; c < 22; c++) begin
            step(1'b0, 1'b1);
            check("wait_before_rst", 1'b0);
        end
        step(1'b1, 1'b1);
        check("rst_mid_wait", 1'b0);
        for (int c = 0; c < 33; c++) begin
            step(1'b0, 1'b1);
            check("fresh_wait", 1'b0);
        end
        step(1'b0, 1'b1);
        check("fresh_rise", 1'b1);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1);
            check("fresh_hold", 1'b1);
        end

        // Randomised runs against the reference model, with rare resets.
        step(1'b1, 1'b0);
        check("rand_reset", m_out);
        for (int t = 0; t < 200; t++) begin
            lvl = 1'($urandom_range(1, 0));
            len = ($urandom_range(3, 0) == 0) ? $urandom_range(40, 25)
                                              : $urandom_range(12, 1);
            for (int i = 0; i < len; i++) begin
                step($urandom_range(399, 0) == 0, lvl);
                check("random", m_out);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
